// File: rtl/cscv_mem_pkg.sv
// Shared definitions for the clocked memory models (ROM now, RAM/UART later).
//   rom_state_e : access FSM states
//   MAX_WAIT    : largest supported wait-state count
//   cnt_width() : counter width needed to hold 0..max_val
//   rom_image() : word stored at linear ROM index (low byte of index ^ 8'hA5)
package cscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } rom_state_e;

    localparam int MAX_WAIT = 15;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    localparam int CNT_W = cnt_width(MAX_WAIT);

    // ROM contents as a pure function of the linear index {bank, addr}.
    // Bits above WordSize are dropped by the caller.
    function automatic logic [31:0] rom_image(input logic [31:0] idx);
        return (idx ^ 32'h0000_00A5) & 32'h0000_00FF;
    endfunction

endpackage

// File: rtl/banked_wait_rom_if.sv
// Request/response bundle between a CPU sequencer (master) and the banked
// wait-state ROM (slave).
//   req/addr       : read request and its CPU-visible address
//   bank_we/bank_in: bank register load
//   busy/rd_valid  : access in progress / one-cycle data-fresh strobe
//   rd_data        : last word read
//   bank/overrun   : current bank register / sticky dropped-request flag
interface banked_wait_rom_if #(
    parameter int AddressSize = 16,
    parameter int WordSize    = 8,
    parameter int BankBits    = 2
) ();
    logic                   req;
    logic [AddressSize-1:0] addr;
    logic                   bank_we;
    logic [BankBits-1:0]    bank_in;
    logic                   busy;
    logic                   rd_valid;
    logic [WordSize-1:0]    rd_data;
    logic [BankBits-1:0]    bank;
    logic                   overrun;

    modport master (
        output req, addr, bank_we, bank_in,
        input  busy, rd_valid, rd_data, bank, overrun
    );

    modport slave (
        input  req, addr, bank_we, bank_in,
        output busy, rd_valid, rd_data, bank, overrun
    );
endinterface

// File: rtl/rom_wait_timer.sv
// Load/decrement wait-state counter.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   load       : load load_val (has priority over dec)
//   load_val   : initial count
//   dec        : decrement by one, saturating at zero
//   expire     : count is 1, i.e. the last wait cycle is in progress
module rom_wait_timer
    import cscv_mem_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expire
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/banked_wait_rom.sv
// Banked ROM with programmable access latency behind a req/valid handshake.
// A request accepted in IDLE captures {bank, addr}; after WaitStates cycles in
// WAIT the FSM spends one cycle in DONE with rd_valid high and the fresh word
// on rd_data. Requests arriving while busy are dropped and set overrun.
//   clk       : system clock, rising edge
//   reset_bar : async active-low reset
//   bus       : slave side of banked_wait_rom_if
module banked_wait_rom
    import cscv_mem_pkg::*;
#(
    parameter int AddressSize = 16,
    parameter int WordSize    = 8,
    parameter int BankBits    = 2,
    parameter int WaitStates  = 2
) (
    input  logic             clk,
    input  logic             reset_bar,
    banked_wait_rom_if.slave bus
);

    localparam int IdxW = AddressSize + BankBits;
    localparam logic [CNT_W-1:0] WaitInit = CNT_W'(WaitStates);

    if ((WaitStates > MAX_WAIT) || (WaitStates < 0)) begin : g_bad_wait
        $error("banked_wait_rom: WaitStates must be within 0..15");
    end

    rom_state_e          state_q, state_d;
    logic [IdxW-1:0]     addr_q, addr_d;
    logic [WordSize-1:0] rd_data_q, rd_data_d;
    logic [BankBits-1:0] bank_q, bank_d;
    logic                overrun_q, overrun_d;

    logic                accept;
    logic                enter_done;
    logic                tmr_expire;
    logic [IdxW-1:0]     rd_idx;

    // Index is exactly IdxW bits wide, so {bank, addr} wraps over the full depth.
    function automatic logic [WordSize-1:0] rom_word(input logic [IdxW-1:0] idx);
        return WordSize'(rom_image(32'(idx)));
    endfunction

    assign accept = (state_q == IDLE) && bus.req;

    rom_wait_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (reset_bar),
        .load     (accept),
        .load_val (WaitInit),
        .dec      (state_q == WAIT),
        .expire   (tmr_expire)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.req) state_d = (WaitStates == 0) ? DONE : WAIT;
            WAIT: if (tmr_expire) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy     = (state_q != IDLE);
        bus.rd_valid = (state_q == DONE);
    end

    // ---------------- Datapath ----------------
    // rd_data is loaded on the edge that enters DONE so the word is already
    // on the bus for the whole rd_valid cycle. With zero wait states that edge
    // is the accept edge, so the address comes straight from the request.
    assign enter_done = (state_d == DONE) && (state_q != DONE);
    assign rd_idx     = (state_q == IDLE) ? {bank_q, bus.addr} : addr_q;

    always_comb begin
        addr_d    = accept ? {bank_q, bus.addr} : addr_q;
        bank_d    = bus.bank_we ? bus.bank_in : bank_q;
        overrun_d = overrun_q | (bus.req && (state_q != IDLE));
        rd_data_d = enter_done ? rom_word(rd_idx) : rd_data_q;
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            addr_q    <= '0;
            rd_data_q <= '0;
            bank_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            rd_data_q <= rd_data_d;
            bank_q    <= bank_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.bank    = bank_q;
    assign bus.overrun = overrun_q;

endmodule
